// File: rtl/uart_tx_feeder.sv
// Byte FIFO between the core's MMIO store path and the UART transmitter.
// Queues pushes in order and drains them one at a time over tx_start/tx_busy.
module uart_tx_feeder #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        tx_sdata,
  output logic              tx_start,
  input  logic              tx_busy
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            push;
  logic            pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign push  = wr_en && !full;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START:     state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: if (tx_busy)  state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (!tx_busy) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      tx_start <= 1'b0;
      tx_sdata <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      tx_start <= pop;
      if (pop) begin
        tx_sdata <= mem[rd_ptr[ADDR_W-1:0]];
        rd_ptr   <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a cycle table for exact handshake timing, then a
// queue scoreboard with a transmitter busy model for overflow, reset and wrap.
module tb_uart_tx_feeder;

  localparam int DEPTH    = 8;
  localparam int BUSY_LEN = 3;
  localparam int NTBL     = 19;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic [7:0] tx_sdata;
  logic       tx_start;
  logic       tx_busy;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_sdata (tx_sdata),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       busy;
    int         cnt;
    logic       emp;
    logic       fl;
    logic       ovf;
    logic       st;
    logic [7:0] sd;
  } vec_t;

  vec_t       tbl [NTBL];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q [$];
  int         model_count;
  bit         model_ovf;
  int         busy_left;
  bit         hold_busy;
  bit         prev_start;
  int         gap;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, model the transmitter, check all outputs.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic r);
    logic [7:0] e;
    @(negedge clk);
    rst     = r;
    wr_en   = we;
    wr_data = wd;
    tx_busy = hold_busy || (busy_left > 0);
    if (busy_left > 0) busy_left--;
    if (gap == 1 && tx_busy) gap = 2;
    else if (gap == 2 && !tx_busy) gap = 0;
    if (tx_start) begin
      chk("start_one_cycle", {31'b0, prev_start}, 0);
      chk("start_after_busy_cycle", gap, 0);
      if (exp_q.size() == 0) begin
        chk("spurious_start", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("tx_sdata_order", {24'b0, tx_sdata}, {24'b0, e});
        model_count--;
      end
      busy_left = BUSY_LEN;
      gap       = 1;
    end
    prev_start = tx_start;
    chk("count", {28'b0, count}, model_count);
    chk("empty", {31'b0, empty}, (model_count == 0) ? 1 : 0);
    chk("full", {31'b0, full}, (model_count == DEPTH) ? 1 : 0);
    chk("overflow", {31'b0, overflow}, {31'b0, model_ovf});
    if (r) begin
      exp_q.delete();
      model_count = 0;
      model_ovf   = 0;
      busy_left   = 0;
      gap         = 0;
      prev_start  = 0;
    end else if (we) begin
      if (model_count == DEPTH) begin
        model_ovf = 1;
      end else begin
        exp_q.push_back(wd);
        model_count++;
      end
    end
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (i < budget && (exp_q.size() != 0 || model_count != 0 || busy_left != 0)) begin
      cycle(1'b0, 8'h00, 1'b0);
      i++;
    end
    chk("drain_complete", exp_q.size(), 0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int guard;

    // inputs: we, wd, busy | expected: count, empty, full, overflow, tx_start, tx_sdata
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[6]  = '{1'b1, 8'h01, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[7]  = '{1'b1, 8'h02, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    tbl[8]  = '{1'b1, 8'h03, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01};
    tbl[9]  = '{1'b1, 8'h04, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02};
    tbl[16] = '{1'b1, 8'h10, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03};
    tbl[18] = '{1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03};

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Exact cycle timing: single byte, burst, and push coinciding with a pop.
    for (int i = 0; i < NTBL; i++) begin
      @(negedge clk);
      wr_en   = tbl[i].we;
      wr_data = tbl[i].wd;
      tx_busy = tbl[i].busy;
      chk($sformatf("tbl%0d_count", i), {28'b0, count}, tbl[i].cnt);
      chk($sformatf("tbl%0d_empty", i), {31'b0, empty}, {31'b0, tbl[i].emp});
      chk($sformatf("tbl%0d_full", i), {31'b0, full}, {31'b0, tbl[i].fl});
      chk($sformatf("tbl%0d_overflow", i), {31'b0, overflow}, {31'b0, tbl[i].ovf});
      chk($sformatf("tbl%0d_tx_start", i), {31'b0, tx_start}, {31'b0, tbl[i].st});
      chk($sformatf("tbl%0d_tx_sdata", i), {24'b0, tx_sdata}, {24'b0, tbl[i].sd});
    end

    // Hand over to the scoreboard with the bytes still queued: 04 then 10 last.
    exp_q       = {8'h04, 8'h10};
    model_count = 2;
    model_ovf   = 0;
    busy_left   = 0;
    hold_busy   = 0;
    prev_start  = 0;
    gap         = 2;
    drain(200);

    // Full/overflow with the transmitter stuck busy.
    hold_busy = 1;
    for (int k = 0; k < DEPTH + 2; k++) cycle(1'b1, 8'(8'h40 + k), 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("ovf_full_flag", {31'b0, full}, 1);
    chk("ovf_sticky_flag", {31'b0, overflow}, 1);
    chk("ovf_count_depth", {28'b0, count}, DEPTH);
    repeat (4) cycle(1'b0, 8'h00, 1'b0);
    hold_busy = 0;
    drain(400);

    // Reset while parked in S_WAIT_DONE holding five bytes.
    hold_busy = 1;
    for (int k = 0; k < 6; k++) cycle(1'b1, 8'(8'h60 + k), 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    chk("rst_pre_count", {28'b0, count}, 5);
    cycle(1'b0, 8'h00, 1'b1);
    hold_busy = 0;
    cycle(1'b0, 8'h00, 1'b0);
    chk("rst_tx_start", {31'b0, tx_start}, 0);
    chk("rst_tx_sdata", {24'b0, tx_sdata}, 0);
    chk("rst_overflow", {31'b0, overflow}, 0);
    repeat (12) cycle(1'b0, 8'h00, 1'b0);

    // Wrap-around stream with random stalls, never allowed to fill.
    sent  = 0;
    guard = 0;
    while (sent < 3 * DEPTH + 5 && guard < 5000) begin
      guard++;
      if (model_count < DEPTH - 1 && $urandom_range(0, 2) != 0) begin
        cycle(1'b1, 8'(sent), 1'b0);
        sent++;
      end else begin
        cycle(1'b0, 8'h00, 1'b0);
      end
    end
    chk("wrap_all_pushed", sent, 3 * DEPTH + 5);
    drain(800);
    chk("wrap_no_overflow", {31'b0, overflow}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
